spgd_dither_step: RTL and testbench
===================================

SPGD_DITHER_STEP -- requirements
Module: spgd_dither_step

Interface
REQ-001 SHALL have parameter FLOAT_WIDTH, default 64, metric word width, signed 16Q48.
REQ-002 SHALL have parameter DAC_WIDTH, default 14, control/DAC code width, unsigned.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, reset value of 16-bit Fibonacci LFSR (taps 16,14,13,11).
REQ-004 SHALL have parameter SKIP, default 1, number of METRIC_VALID strobes discarded after each phase entry (settling).
REQ-005 SHALL have ports: ADC_CLK in 1, sole clock; RST in 1, synchronous active-high reset.
REQ-006 SHALL have ports: enable in 1; METRIC_VALID in 1, one-cycle strobe; METRIC_IN in FLOAT_WIDTH, signed 16Q48 measured metric.
REQ-007 SHALL have ports: DITHER_AMP in DAC_WIDTH, perturbation in codes; GAIN_SHIFT in 6, right-shift gain; U_INIT in DAC_WIDTH, initial control.
REQ-008 SHALL have ports: DAC_CODE_OUT out DAC_WIDTH; PERTURB_SIGN out 1 (1 = +); STEP_DONE out 1, one-cycle pulse; ITER_COUNT out 32.

Function
REQ-009 SHALL implement states IDLE, POS, NEG, UPDATE; IDLE->POS when enable=1; POS->NEG and NEG->UPDATE on the first non-discarded METRIC_VALID; UPDATE->POS (enable=1) or IDLE (enable=0) after exactly one cycle.
REQ-010 SHALL, per phase, discard the first SKIP METRIC_VALID strobes via a counter cleared on phase entry; the next strobe captures METRIC_IN into Jp (POS) or Jn (NEG).
REQ-011 SHALL register DAC_CODE_OUT: IDLE/UPDATE = u; POS = u + s*DITHER_AMP; NEG = u - s*DITHER_AMP; s = PERTURB_SIGN as +/-1; each value clamped to [0, 2^DAC_WIDTH-1] using DAC_WIDTH+2-bit signed intermediate.
REQ-012 SHALL, in UPDATE, compute dJ = Jp - Jn at FLOAT_WIDTH+1 bits, arithmetic-shift right by GAIN_SHIFT, take integer bits [FLOAT_WIDTH:48] (truncation toward minus infinity), saturate to +/-(2^(DAC_WIDTH-1)-1) as step.
REQ-013 SHALL set u <= clamp(u + s*step, 0, 2^DAC_WIDTH-1) at end of UPDATE; DAC_CODE_OUT shows new u the following cycle.
REQ-014 SHALL pulse STEP_DONE for the cycle u is written, advance LFSR one step that same cycle, and load PERTURB_SIGN = LFSR bit 0 on POS entry; sign constant through POS/NEG/UPDATE.
REQ-015 SHALL, when enable falls in any state, go to IDLE next cycle, drive u unperturbed, retain u, Jp, Jn, LFSR, and discard any METRIC_VALID in that cycle (enable wins).
REQ-016 SHALL ignore METRIC_VALID in IDLE and UPDATE.
REQ-017 SHALL increment ITER_COUNT on each STEP_DONE, wrapping 2^32-1 -> 0.

Reset
REQ-018 SHALL, with RST=1 at a clock edge, override all other inputs: state IDLE, u <= U_INIT, DAC_CODE_OUT <= 0, PERTURB_SIGN <= 0, STEP_DONE <= 0, ITER_COUNT <= 0, Jp = Jn = 0, skip counters 0, LFSR <= LFSR_SEED.
REQ-019 SHALL, on reset mid-iteration, abandon the iteration with no u update and no STEP_DONE.

Configuration
REQ-020 SHALL, with SPGD_ITER_COUNT_EN defined, implement the ITER_COUNT counter per REQ-017.
REQ-021 SHALL, with SPGD_ITER_COUNT_EN undefined, tie ITER_COUNT to 0 and omit the counter; all other behaviour unchanged.

Verification
REQ-022 SHALL cover: U_INIT=8192, AMP=100, SKIP=1, s=+1, Jp=64.0 (0x0040_0000_0000_0000), Jn=0, GAIN_SHIFT=0 -> POS out 8292, NEG out 8092, u=8256, one STEP_DONE.
REQ-023 SHALL cover: same stimulus with GAIN_SHIFT=2 and s=-1 -> POS out 8092, NEG out 8292, u=8176.
REQ-024 SHALL cover: U_INIT=16380, AMP=100, s=+1 -> POS out 16383, NEG out 16280; Jp-Jn=-20000.0 -> step saturates -8191, u=8189.
REQ-025 SHALL cover: SKIP=2; three strobes in POS with values 1.0, 2.0, 5.0 -> Jp=5.0 captured, earlier two discarded.
REQ-026 SHALL cover: enable dropped in NEG -> IDLE next cycle, out=u unchanged, no STEP_DONE; RST pulsed in UPDATE -> u=U_INIT, ITER_COUNT=0, LFSR=0xACE1.
REQ-027 SHALL cover: build without SPGD_ITER_COUNT_EN, 3 iterations -> ITER_COUNT=0, u identical to enabled build.

Source files
------------

// File: rtl/spgd_dither_step.sv
// SPGD dither/step controller: two-sided perturbation, metric capture, gradient step on the DAC code.
// Optional SPGD_ITER_COUNT_EN: when defined, ITER_COUNT counts completed steps; otherwise it is tied to 0.
module spgd_dither_step #(
  parameter int          FLOAT_WIDTH = 64,
  parameter int          DAC_WIDTH   = 14,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          SKIP        = 1
) (
  input  logic                          ADC_CLK,
  input  logic                          RST,
  input  logic                          enable,
  input  logic                          METRIC_VALID,
  input  logic signed [FLOAT_WIDTH-1:0] METRIC_IN,
  input  logic        [DAC_WIDTH-1:0]   DITHER_AMP,
  input  logic        [5:0]             GAIN_SHIFT,
  input  logic        [DAC_WIDTH-1:0]   U_INIT,
  output logic        [DAC_WIDTH-1:0]   DAC_CODE_OUT,
  output logic                          PERTURB_SIGN,
  output logic                          STEP_DONE,
  output logic        [31:0]            ITER_COUNT
);

  localparam int FRAC = 48;
  localparam int SW   = DAC_WIDTH + 2;
  localparam int CW   = (SKIP > 1) ? $clog2(SKIP + 1) : 1;

  localparam logic signed [FLOAT_WIDTH:0] STEP_MAX = (FLOAT_WIDTH+1)'(2**(DAC_WIDTH-1) - 1);
  localparam logic signed [FLOAT_WIDTH:0] STEP_MIN = -STEP_MAX;

  typedef enum logic [1:0] {IDLE, POS, NEG, UPDATE} state_t;

  state_t                        state, nxt;
  logic        [DAC_WIDTH-1:0]   u, u_nx, dac_nx;
  logic signed [FLOAT_WIDTH-1:0] jp, jn, jp_nx, jn_nx;
  logic        [15:0]            lfsr, lfsr_nx, lfsr_adv;
  logic        [CW-1:0]          skip_cnt, skip_nx;
  logic                          sign_nx, done_nx;

  logic signed [FLOAT_WIDTH:0]   dj, dj_q;
  logic signed [DAC_WIDTH-1:0]   step;
  logic signed [SW-1:0]          step_x, amp_x, upd_v, pos_v, neg_v;

  function automatic logic [DAC_WIDTH-1:0] clamp(input logic signed [SW-1:0] v);
    if (v < 0)
      return '0;
    else if (v > $signed({2'b00, {DAC_WIDTH{1'b1}}}))
      return '1;
    else
      return v[DAC_WIDTH-1:0];
  endfunction

  assign lfsr_adv = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Shifting by GAIN_SHIFT+48 equals shifting by GAIN_SHIFT and keeping bits [FLOAT_WIDTH:48].
  always_comb begin
    dj   = {jp[FLOAT_WIDTH-1], jp} - {jn[FLOAT_WIDTH-1], jn};
    dj_q = dj >>> (GAIN_SHIFT + FRAC);
    if (dj_q > STEP_MAX)
      step = STEP_MAX[DAC_WIDTH-1:0];
    else if (dj_q < STEP_MIN)
      step = STEP_MIN[DAC_WIDTH-1:0];
    else
      step = dj_q[DAC_WIDTH-1:0];
    step_x = {{2{step[DAC_WIDTH-1]}}, step};
    upd_v  = $signed({2'b00, u}) + (PERTURB_SIGN ? step_x : -step_x);
  end

  always_comb begin
    nxt     = state;
    u_nx    = u;
    jp_nx   = jp;
    jn_nx   = jn;
    lfsr_nx = lfsr;
    sign_nx = PERTURB_SIGN;
    skip_nx = skip_cnt;
    done_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          nxt     = POS;
          sign_nx = lfsr[0];
          skip_nx = '0;
        end
      end
      POS: begin
        if (!enable)
          nxt = IDLE;
        else if (METRIC_VALID) begin
          if (32'(skip_cnt) < 32'(SKIP))
            skip_nx = skip_cnt + CW'(1);
          else begin
            jp_nx   = METRIC_IN;
            skip_nx = '0;
            nxt     = NEG;
          end
        end
      end
      NEG: begin
        if (!enable)
          nxt = IDLE;
        else if (METRIC_VALID) begin
          if (32'(skip_cnt) < 32'(SKIP))
            skip_nx = skip_cnt + CW'(1);
          else begin
            jn_nx   = METRIC_IN;
            skip_nx = '0;
            nxt     = UPDATE;
          end
        end
      end
      UPDATE: begin
        u_nx    = clamp(upd_v);
        done_nx = 1'b1;
        lfsr_nx = lfsr_adv;
        if (enable) begin
          nxt     = POS;
          sign_nx = lfsr_adv[0];
          skip_nx = '0;
        end else
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Output code is registered from the next state so it lines up with the phase it belongs to.
  always_comb begin
    amp_x  = $signed({2'b00, DITHER_AMP});
    pos_v  = $signed({2'b00, u_nx}) + (sign_nx ? amp_x : -amp_x);
    neg_v  = $signed({2'b00, u_nx}) - (sign_nx ? amp_x : -amp_x);
    dac_nx = u_nx;
    if (nxt == POS)
      dac_nx = clamp(pos_v);
    else if (nxt == NEG)
      dac_nx = clamp(neg_v);
  end

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state        <= IDLE;
      u            <= U_INIT;
      jp           <= '0;
      jn           <= '0;
      lfsr         <= LFSR_SEED;
      skip_cnt     <= '0;
      PERTURB_SIGN <= 1'b0;
      DAC_CODE_OUT <= '0;
      STEP_DONE    <= 1'b0;
    end else begin
      state        <= nxt;
      u            <= u_nx;
      jp           <= jp_nx;
      jn           <= jn_nx;
      lfsr         <= lfsr_nx;
      skip_cnt     <= skip_nx;
      PERTURB_SIGN <= sign_nx;
      DAC_CODE_OUT <= dac_nx;
      STEP_DONE    <= done_nx;
    end
  end

`ifdef SPGD_ITER_COUNT_EN
  logic [31:0] iter;

  always_ff @(posedge ADC_CLK) begin
    if (RST)
      iter <= '0;
    else if (done_nx)
      iter <= iter + 32'd1;
  end

  assign ITER_COUNT = iter;
`else
  assign ITER_COUNT = '0;
`endif

endmodule

// File: tb/tb_spgd_dither_step.sv
// Scoreboard bench for spgd_dither_step: main instance with SKIP=1, second instance with SKIP=2.
module tb_spgd_dither_step;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b, mv;
  logic [63:0] mi;
  logic [13:0] amp, uinit;
  logic [5:0]  gain;

  logic [13:0] dac_a, dac_b;
  logic        sign_a, sign_b, done_a, done_b;
  logic [31:0] iter_a, iter_b;

  always #5 clk = ~clk;

  spgd_dither_step #(.FLOAT_WIDTH(64), .DAC_WIDTH(14), .LFSR_SEED(16'hACE1), .SKIP(1)) dut (
    .ADC_CLK(clk), .RST(rst), .enable(en_a), .METRIC_VALID(mv), .METRIC_IN(mi),
    .DITHER_AMP(amp), .GAIN_SHIFT(gain), .U_INIT(uinit),
    .DAC_CODE_OUT(dac_a), .PERTURB_SIGN(sign_a), .STEP_DONE(done_a), .ITER_COUNT(iter_a)
  );

  spgd_dither_step #(.FLOAT_WIDTH(64), .DAC_WIDTH(14), .LFSR_SEED(16'hACE1), .SKIP(2)) dut_skip2 (
    .ADC_CLK(clk), .RST(rst), .enable(en_b), .METRIC_VALID(mv), .METRIC_IN(mi),
    .DITHER_AMP(amp), .GAIN_SHIFT(gain), .U_INIT(uinit),
    .DAC_CODE_OUT(dac_b), .PERTURB_SIGN(sign_b), .STEP_DONE(done_b), .ITER_COUNT(iter_b)
  );

  typedef struct {
    longint dac;
    longint iter;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  int          m_u, m_s;
  logic [15:0] m_lfsr;
  longint      m_iter;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > 16383) return 16383;
    return v;
  endfunction

  function automatic int model_step(input longint jp, input longint jn, input int gs);
    longint q;
    q = (jp - jn) >>> (48 + gs);
    if (q > 8191) return 8191;
    if (q < -8191) return -8191;
    return int'(q);
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic longint exp_iter();
`ifdef SPGD_ITER_COUNT_EN
    return m_iter;
`else
    return 0;
`endif
  endfunction

  function automatic int pert(input int u, input int s, input int a);
    return clampi(s != 0 ? u + a : u - a);
  endfunction

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (sb.size() == 0)
        check("step_done_spurious", longint'(done_a), 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("step_dac", longint'(dac_a), e.dac);
        check("step_iter", longint'(iter_a), e.iter);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input longint v);
    mv = 1'b1;
    mi = v;
    tick();
    mv = 1'b0;
    mi = '0;
    tick();
  endtask

  task automatic do_reset(input int ui);
    rst   = 1'b1;
    uinit = 14'(ui);
    en_a  = 1'b0;
    en_b  = 1'b0;
    mv    = 1'b0;
    tick();
    check("rst_dac", longint'(dac_a), 0);
    check("rst_sign", longint'(sign_a), 0);
    check("rst_done", longint'(done_a), 0);
    check("rst_iter", longint'(iter_a), 0);
    rst = 1'b0;
    tick();
    check("rst_idle_dac", longint'(dac_a), longint'(ui));
    m_u    = ui;
    m_lfsr = 16'hACE1;
    m_iter = 0;
  endtask

  // One full iteration on the SKIP=1 instance, ending back in IDLE.
  task automatic iterate_a(input longint jp, input longint jn, input int gs);
    int st;
    gain = 6'(gs);
    en_a = 1'b1;
    tick();
    m_s = int'(m_lfsr[0]);
    check("pos_sign", longint'(sign_a), longint'(m_s));
    check("pos_dac", longint'(dac_a), longint'(pert(m_u, m_s, int'(amp))));
    pulse(64'sd7 <<< 48);
    pulse(jp);
    check("neg_dac", longint'(dac_a), longint'(pert(m_u, 1 - m_s, int'(amp))));
    pulse(64'sd9 <<< 48);
    st     = model_step(jp, jn, gs);
    m_u    = clampi(m_s != 0 ? m_u + st : m_u - st);
    m_lfsr = lfsr_adv(m_lfsr);
    m_iter++;
    sb.push_back('{dac: longint'(pert(m_u, int'(m_lfsr[0]), int'(amp))), iter: exp_iter()});
    pulse(jn);
    en_a = 1'b0;
    mv   = 1'b1;
    mi   = 64'sd3 <<< 48;
    tick();
    mv   = 1'b0;
    mi   = '0;
    check("idle_u", longint'(dac_a), longint'(m_u));
  endtask

  initial begin
    rst  = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    mv   = 1'b0;
    mi   = '0;
    amp  = 14'd100;
    gain = 6'd0;

    // Nominal step: u 8192 -> 8256
    do_reset(8192);
    iterate_a(64'sd64 <<< 48, 0, 0);
    check("r22_u", longint'(dac_a), 8256);

    // Zero-gradient iteration then s=-1 step with gain shift 2
    do_reset(8192);
    iterate_a(64'sd5 <<< 48, 64'sd5 <<< 48, 2);
    iterate_a(64'sd64 <<< 48, 0, 2);
    check("r23_u", longint'(dac_a), 8176);
    iterate_a(64'sd1 <<< 50, 64'sd3 <<< 47, 1);

    // Upper clamp on perturbation and negative step saturation
    do_reset(16380);
    iterate_a(0, 64'sd20000 <<< 48, 0);
    check("r24_u", longint'(dac_a), 8189);

    // SKIP=2 instance: only the third strobe per phase is captured
    do_reset(8192);
    en_b = 1'b1;
    tick();
    check("skip2_pos", longint'(dac_b), 8292);
    pulse(64'sd1 <<< 48);
    pulse(64'sd2 <<< 48);
    check("skip2_still_pos", longint'(dac_b), 8292);
    pulse(64'sd5 <<< 48);
    check("skip2_neg", longint'(dac_b), 8092);
    pulse(0);
    pulse(0);
    pulse(0);
    check("skip2_done", longint'(done_b), 1);
    check("skip2_step_dac", longint'(dac_b), 8097);
    en_b = 1'b0;
    tick();
    check("skip2_u", longint'(dac_b), 8197);

    // Enable dropped in NEG: back to IDLE with u intact and no step
    do_reset(8192);
    iterate_a(64'sd64 <<< 48, 0, 0);
    en_a = 1'b1;
    tick();
    check("drop_pos_dac", longint'(dac_a), 8156);
    pulse(64'sd1 <<< 48);
    pulse(64'sd1 <<< 48);
    check("drop_neg_dac", longint'(dac_a), 8356);
    en_a = 1'b0;
    mv   = 1'b1;
    mi   = 64'sd1 <<< 48;
    tick();
    mv   = 1'b0;
    check("drop_idle_dac", longint'(dac_a), 8256);
    tick();
    tick();
    check("drop_no_done", longint'(done_a), 0);
    check("drop_dac_hold", longint'(dac_a), 8256);
    iterate_a(0, 64'sd64 <<< 48, 0);
    check("drop_resume_u", longint'(dac_a), 8320);

    // Reset while in UPDATE: iteration abandoned, LFSR restarts from seed
    en_a = 1'b1;
    tick();
    pulse(0);
    pulse(64'sd64 <<< 48);
    pulse(0);
    mv = 1'b1;
    mi = 0;
    tick();
    mv = 1'b0;
    do_reset(8192);
    iterate_a(64'sd64 <<< 48, 0, 0);
    check("post_rst_u", longint'(dac_a), 8256);
    iterate_a(64'sd64 <<< 48, 0, 0);
    check("post_rst_u2", longint'(dac_a), 8192);

    tick();
    check("sb_empty", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
